uart_tx_serializer: RTL and testbench
=====================================

// Module: uart_tx_serializer
// PURPOSE
//  Downstream consumer of the TX controller byte stream: accepts one parallel word per
//  DATA_VALID and serialises it as a UART frame: start bit, data LSB-first, optional parity, stop.
//  Runs in the UART TX clock domain at one bit per CLK cycle.
//  Drives Busy back to the TX controller as the flow-control handshake.
// PARAMETERS
//  DATA_WIDTH  8  data bits per frame (P_DATA width)
// PORTS
//  CLK         in   1           UART TX bit clock; all state on rising edge
//  RST         in   1           asynchronous, active-low reset
//  P_DATA      in   DATA_WIDTH  parallel word to send
//  DATA_VALID  in   1           P_DATA valid; may be held high for several cycles
//  PAR_EN      in   1           1 = insert parity bit
//  PAR_TYP     in   1           0 = even parity, 1 = odd parity
//  TX_OUT      out  1           serial line; idle high
//  Busy        out  1           1 while a frame is in progress (start through last stop bit)
// BEHAVIOUR
//  - TX_OUT and Busy are registered outputs. Reset values: TX_OUT=1, Busy=0, FSM=IDLE.
//    Shift register, bit counter and latched parity/config are all cleared.
//  - Reset asserted mid-frame aborts the frame immediately (async): TX_OUT=1 and Busy=0.
//    No partial frame resumes after release.
//  - FSM states: IDLE, START, DATA, PARITY, STOP.
//  - IDLE: TX_OUT=1, Busy=0.
//    If DATA_VALID=1 at edge k:
//      * latch P_DATA, PAR_EN, PAR_TYP;
//      * compute par = ^P_DATA ^ PAR_TYP;
//      * go to START.
//    From edge k: TX_OUT=0, Busy=1. Start bit is present during cycle k+1.
//  - START -> DATA after 1 cycle. TX_OUT = data[0].
//  - DATA: emits bits 0..DATA_WIDTH-1 LSB-first, one per cycle.
//    Counter width $clog2(DATA_WIDTH), counts 0..DATA_WIDTH-1.
//    At the last bit: go to PARITY if latched PAR_EN=1, else go to STOP.
//  - PARITY: TX_OUT = latched par for 1 cycle, then STOP.
//  - STOP: TX_OUT=1, Busy=1 for 1 cycle, then IDLE (Busy=0).
//  - Frame length in cycles with Busy=1: 2 + DATA_WIDTH + PAR_EN
//    (+1 when UART_TX_STOP2_EN is defined).
//  - DATA_VALID is ignored whenever state != IDLE. P_DATA/PAR_EN/PAR_TYP changes mid-frame
//    have no effect.
//  - Back-to-back: after STOP, IDLE with Busy=0 lasts at least 1 cycle.
//    A DATA_VALID held high is accepted on that IDLE cycle, so the inter-frame gap is 1 idle-high cycle.
//  - DATA_VALID=1 coincident with reset release: ignored until the first edge with RST=1 in IDLE.
//  - Invalid/unused state encodings recover to IDLE with TX_OUT=1, Busy=0.
// CONFIGURATION
//  UART_TX_STOP2_EN
//    defined:   STOP lasts 2 cycles (two stop bits, TX_OUT=1, Busy=1 throughout).
//    undefined: single stop bit as above.
//  Port list is identical in both builds.
// TESTING
//  1. Reset check: RST=0 -> TX_OUT=1, Busy=0. Release RST with DATA_VALID=0 for 20 cycles
//     -> TX_OUT stays 1, Busy stays 0.
//  2. Even parity: P_DATA=8'hA5, PAR_EN=1, PAR_TYP=0, DATA_VALID pulse 1 cycle
//     -> TX_OUT = 0,1,0,1,0,0,1,0,1,0,1 (start, data LSB-first, parity 0, stop).
//     Busy=1 for exactly 11 cycles.
//  3. Odd parity and parity disabled:
//     - 8'hA5, PAR_TYP=1 -> parity bit 1.
//     - 8'h3C, PAR_EN=0 -> 0,0,0,1,1,1,1,0,0,1; Busy=1 for 10 cycles.
//  4. Held DATA_VALID with P_DATA toggling mid-frame (8'h01 -> 8'hFF at bit 3)
//     -> first frame carries 8'h01 unchanged.
//     -> second frame starts after exactly 1 idle cycle and carries the value present at that IDLE cycle.
//  5. RST pulsed low during data bit 4 -> TX_OUT=1, Busy=0 immediately.
//     A new 8'h55 after release is sent as a complete, correct frame.
//  6. Build with UART_TX_STOP2_EN, send 8'hA5, PAR_EN=1
//     -> 2 stop-bit cycles high; Busy=1 for 12 cycles.

Source files
------------

// File: rtl/uart_tx_serializer_if.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer_if
//
// Handshake bundle between the TX controller (master) and the UART frame
// serializer (slave).
//
//   P_DATA      master -> slave  parallel word to send
//   DATA_VALID  master -> slave  P_DATA valid (may be held for several cycles)
//   PAR_EN      master -> slave  1 = append a parity bit
//   PAR_TYP     master -> slave  0 = even parity, 1 = odd parity
//   TX_OUT      slave  -> master serial line, idle high
//   Busy        slave  -> master high from start bit through last stop bit
// ---------------------------------------------------------------------------
interface uart_tx_serializer_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  TX_OUT;
    logic                  Busy;

    modport master (
        output P_DATA,
        output DATA_VALID,
        output PAR_EN,
        output PAR_TYP,
        input  TX_OUT,
        input  Busy
    );

    modport slave (
        input  P_DATA,
        input  DATA_VALID,
        input  PAR_EN,
        input  PAR_TYP,
        output TX_OUT,
        output Busy
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
//
// Turns one parallel word per accepted DATA_VALID into a UART frame:
// start bit (0), DATA_WIDTH data bits LSB-first, optional parity bit, and a
// stop bit (1). One bit is emitted per CLK cycle. Busy is the flow-control
// handshake back to the TX controller.
//
// Ports
//   CLK   in   UART TX bit clock, rising edge
//   RST   in   asynchronous, active-low reset
//   bus   slave modport of uart_tx_serializer_if
//           P_DATA / DATA_VALID / PAR_EN / PAR_TYP in, TX_OUT / Busy out
//
// Build option
//   UART_TX_STOP2_EN  when defined, the stop phase lasts two cycles (two stop
//                     bits). The port list is the same in both builds.
//
// TX_OUT and Busy are registered: the combinational block computes the value
// the line must carry during the *next* cycle, so every output change lines
// up with the state change that causes it.
// ---------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    uart_tx_serializer_if.slave   bus
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                state_reg,   state_next;
    logic [DATA_WIDTH-1:0] shift_reg,   shift_next;
    logic [CNT_W-1:0]      bit_cnt_reg, bit_cnt_next;
    logic                  par_en_reg,  par_en_next;
    logic                  par_bit_reg, par_bit_next;
    logic                  tx_out_reg,  tx_out_next;
    logic                  busy_reg,    busy_next;
`ifdef UART_TX_STOP2_EN
    // 0 while the first stop bit is on the line, 1 during the second.
    logic                  stop_cnt_reg, stop_cnt_next;
`endif

    // -----------------------------------------------------------------------
    // Parity of the incoming word, folded with PAR_TYP so that odd parity
    // simply inverts the even result. Computed on the live inputs because it
    // is latched on the same edge that accepts the word.
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH:0] par_chain;
    logic                par_in;

    assign par_chain[0] = bus.PAR_TYP;

    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_par
            assign par_chain[gi+1] = par_chain[gi] ^ bus.P_DATA[gi];
        end
    endgenerate

    assign par_in = par_chain[DATA_WIDTH];

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg    <= S_IDLE;
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            par_en_reg   <= 1'b0;
            par_bit_reg  <= 1'b0;
            tx_out_reg   <= 1'b1;
            busy_reg     <= 1'b0;
`ifdef UART_TX_STOP2_EN
            stop_cnt_reg <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            bit_cnt_reg  <= bit_cnt_next;
            par_en_reg   <= par_en_next;
            par_bit_reg  <= par_bit_next;
            tx_out_reg   <= tx_out_next;
            busy_reg     <= busy_next;
`ifdef UART_TX_STOP2_EN
            stop_cnt_reg <= stop_cnt_next;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        bit_cnt_next  = bit_cnt_reg;
        par_en_next   = par_en_reg;
        par_bit_next  = par_bit_reg;
        tx_out_next   = tx_out_reg;
        busy_next     = busy_reg;
`ifdef UART_TX_STOP2_EN
        stop_cnt_next = stop_cnt_reg;
`endif

        case (state_reg)
            S_IDLE: begin
                tx_out_next = 1'b1;
                busy_next   = 1'b0;
                if (bus.DATA_VALID) begin
                    // Snapshot word and config; later input changes cannot
                    // affect the frame in flight.
                    state_next   = S_START;
                    shift_next   = bus.P_DATA;
                    par_en_next  = bus.PAR_EN;
                    par_bit_next = par_in;
                    bit_cnt_next = '0;
                    tx_out_next  = 1'b0;
                    busy_next    = 1'b1;
                end
            end

            S_START: begin
                // Start bit is on the line; line up data bit 0 for next cycle.
                state_next   = S_DATA;
                tx_out_next  = shift_reg[0];
                shift_next   = shift_reg >> 1;
                bit_cnt_next = '0;
                busy_next    = 1'b1;
            end

            S_DATA: begin
                // bit_cnt_reg is the index of the bit currently on the line.
                busy_next = 1'b1;
                if (bit_cnt_reg == LAST_BIT) begin
                    if (par_en_reg) begin
                        state_next  = S_PARITY;
                        tx_out_next = par_bit_reg;
                    end else begin
                        state_next  = S_STOP;
                        tx_out_next = 1'b1;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                    tx_out_next  = shift_reg[0];
                    shift_next   = shift_reg >> 1;
                end
            end

            S_PARITY: begin
                state_next  = S_STOP;
                tx_out_next = 1'b1;
                busy_next   = 1'b1;
            end

            S_STOP: begin
`ifdef UART_TX_STOP2_EN
                if (!stop_cnt_reg) begin
                    // Hold the line high for a second stop bit.
                    stop_cnt_next = 1'b1;
                    tx_out_next   = 1'b1;
                    busy_next     = 1'b1;
                end else begin
                    stop_cnt_next = 1'b0;
                    state_next    = S_IDLE;
                    tx_out_next   = 1'b1;
                    busy_next     = 1'b0;
                end
`else
                // Always pass through IDLE: DATA_VALID is only sampled there,
                // which guarantees one idle-high cycle between frames.
                state_next  = S_IDLE;
                tx_out_next = 1'b1;
                busy_next   = 1'b0;
`endif
            end

            default: begin
                // Unused encodings fall back to a quiet idle line.
                state_next  = S_IDLE;
                tx_out_next = 1'b1;
                busy_next   = 1'b0;
            end
        endcase
    end

    assign bus.TX_OUT = tx_out_reg;
    assign bus.Busy   = busy_reg;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_serializer
//
// Scoreboard bench for uart_tx_serializer. Stimulus pushes the expected
// frame (line bits in transmission order plus length) when it offers a word;
// a monitor samples TX_OUT/Busy on every falling edge, collects the bits of
// each Busy window and compares them against the queue head when Busy drops.
// Expected data/parity values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_uart_tx_serializer;

    localparam int DW = 8;
`ifdef UART_TX_STOP2_EN
    localparam int STOP_BITS = 2;
`else
    localparam int STOP_BITS = 1;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b1;

    uart_tx_serializer_if #(.DATA_WIDTH(DW)) bus ();

    uart_tx_serializer #(.DATA_WIDTH(DW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] bits;
        int          len;
        string       name;
    } frame_t;

    frame_t exp_q[$];
    frame_t mon_f;
    int     n_tests = 0;
    int     n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame as it must appear on the line; bit i is the i-th transmitted bit.
    function automatic frame_t mk(input string name, input logic [7:0] d,
                                  input logic pen, input logic pbit);
        frame_t f;
        f.name = name;
        f.bits = '0;
        f.len  = 0;
        f.bits[f.len] = 1'b0;
        f.len++;
        for (int i = 0; i < 8; i++) begin
            f.bits[f.len] = d[i];
            f.len++;
        end
        if (pen) begin
            f.bits[f.len] = pbit;
            f.len++;
        end
        for (int i = 0; i < STOP_BITS; i++) begin
            f.bits[f.len] = 1'b1;
            f.len++;
        end
        return f;
    endfunction

    // ---------------- monitor ----------------
    logic [15:0] cap;
    int          cap_len  = 0;
    int          gap      = 0;
    int          last_gap = 0;
    bit          in_frame = 0;
    bit          mon_en   = 0;

    always @(negedge CLK) begin
        if (!RST) begin
            cap      = '0;
            cap_len  = 0;
            in_frame = 0;
            gap      = 0;
        end else if (mon_en) begin
            if (bus.Busy) begin
                if (!in_frame) begin
                    in_frame = 1;
                    last_gap = gap;
                    cap      = '0;
                    cap_len  = 0;
                end
                if (cap_len < 16) cap[cap_len] = bus.TX_OUT;
                cap_len++;
            end else begin
                if (in_frame) begin
                    in_frame = 0;
                    gap      = 0;
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("[TB] FAIL unexpected_frame: got bits 0x%0h len %0d, expected none", cap, cap_len);
                    end else begin
                        mon_f = exp_q.pop_front();
                        check({mon_f.name, "_bits"}, cap, mon_f.bits);
                        check({mon_f.name, "_len"}, cap_len, mon_f.len);
                        $display("[TB] frame %s: bits 0x%0h len %0d", mon_f.name, cap, cap_len);
                    end
                end
                gap++;
                check("idle_tx_high", bus.TX_OUT, 1);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_idle(input string name);
        int k = 0;
        while (bus.Busy === 1'b1 && k < 64) begin
            @(negedge CLK);
            k++;
        end
        check(name, bus.Busy, 0);
        @(negedge CLK);
    endtask

    task automatic send(input frame_t f, input logic [7:0] d, input logic pen, input logic typ);
        @(negedge CLK);
        bus.P_DATA     = d;
        bus.PAR_EN     = pen;
        bus.PAR_TYP    = typ;
        bus.DATA_VALID = 1'b1;
        exp_q.push_back(f);
        @(posedge CLK);
        #1 bus.DATA_VALID = 1'b0;
        @(negedge CLK);
        wait_idle({f.name, "_done"});
    endtask

    initial begin
        int k;
        bus.P_DATA     = '0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        bus.DATA_VALID = 1'b0;

        // Reset state
        #2 RST = 1'b0;
        #1;
        check("reset_tx", bus.TX_OUT, 1);
        check("reset_busy", bus.Busy, 0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST    = 1'b1;
        mon_en = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            check("post_reset_busy", bus.Busy, 0);
        end

        // 8'hA5 has four ones: even parity 0, odd parity 1. 8'h3C without parity.
        send(mk("a5_even", 8'hA5, 1'b1, 1'b0), 8'hA5, 1'b1, 1'b0);
        send(mk("a5_odd", 8'hA5, 1'b1, 1'b1), 8'hA5, 1'b1, 1'b1);
        send(mk("3c_nopar", 8'h3C, 1'b0, 1'b0), 8'h3C, 1'b0, 1'b1);

        // Held DATA_VALID, word changes while bit 3 is on the line.
        // 8'h01 even parity 1, 8'hFF even parity 0.
        @(negedge CLK);
        bus.P_DATA     = 8'h01;
        bus.PAR_EN     = 1'b1;
        bus.PAR_TYP    = 1'b0;
        bus.DATA_VALID = 1'b1;
        exp_q.push_back(mk("held_01", 8'h01, 1'b1, 1'b1));
        @(posedge CLK);
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        bus.P_DATA = 8'hFF;
        exp_q.push_back(mk("held_ff", 8'hFF, 1'b1, 1'b0));
        k = 0;
        while (bus.Busy === 1'b1 && k < 32) begin
            @(negedge CLK);
            k++;
        end
        k = 0;
        while (bus.Busy !== 1'b1 && k < 8) begin
            @(negedge CLK);
            k++;
        end
        check("b2b_restart", bus.Busy, 1);
        bus.DATA_VALID = 1'b0;
        wait_idle("held_ff_done");
        check("b2b_gap", last_gap, 1);

        // Abort during data bit 4 (8'h55, not expected on the scoreboard).
        @(negedge CLK);
        bus.P_DATA     = 8'h55;
        bus.PAR_EN     = 1'b1;
        bus.PAR_TYP    = 1'b0;
        bus.DATA_VALID = 1'b1;
        @(posedge CLK);
        #1 bus.DATA_VALID = 1'b0;
        repeat (5) @(posedge CLK);
        #3 RST = 1'b0;
        #1;
        check("abort_tx", bus.TX_OUT, 1);
        check("abort_busy", bus.Busy, 0);
        repeat (2) @(negedge CLK);
        #2 RST = 1'b1;
        // 8'h55 has four ones: even parity 0.
        send(mk("55_after_rst", 8'h55, 1'b1, 1'b0), 8'h55, 1'b1, 1'b0);

        repeat (5) @(negedge CLK);
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
